// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// The fetch FSM, the ROM geometry and the FIFO entry layout live here.
package fetch_pkg;

    localparam int              AW_DEF          = 8;
    localparam int              DW_DEF          = 16;
    localparam logic [7:0]      RESET_PC_DEF    = 8'h00;
    localparam logic [15:0]     HALT_OPCODE_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] code;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry valid/ready FIFO with synchronous flush; slot0 is always the head,
// so the head outputs come straight from a register and hold while stalled.
module fetch_fifo2 #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         space_o,
    output logic         head_valid_o,
    input  logic         head_ready_i,
    output logic [W-1:0] head_data_o
);

    logic [W-1:0] slot0_q, slot1_q;
    logic [1:0]   count_q;
    logic         pop;

    assign head_valid_o = (count_q != 2'd0);
    assign head_data_o  = slot0_q;
    assign pop          = head_valid_o & head_ready_i;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign space_o      = (count_q != 2'd2) | pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= push_data_i;
                    else                 slot1_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_q <= push_data_i;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM
// and queues {pc, code} pairs for decode, steered by redirect/halt/start.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              AW          = AW_DEF,
    parameter int              DW          = DW_DEF,
    parameter logic [AW-1:0]   RESET_PC    = AW'(RESET_PC_DEF),
    parameter logic [DW-1:0]   HALT_OPCODE = DW'(HALT_OPCODE_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt_req,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    output logic          busy,
    output logic          wrapped
);

    fetch_state_e     state_q;
    logic [AW-1:0]    pc_q;
    logic             wrapped_q;
    logic             busy_q;
    logic             fifo_space;
    logic             flush;
    logic             push;
    logic [AW+DW-1:0] head;

    // Redirect is ignored while idle; otherwise it beats halt_req and fetch.
    assign flush = redirect_valid && (state_q != ST_IDLE);
    assign push  = (state_q == ST_FETCH) && !redirect_valid && !halt_req && fifo_space;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (flush) begin
            state_q   <= ST_FETCH;
            pc_q      <= redirect_pc;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b1;
        end else if (halt_req) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q   <= ST_FETCH;
                    pc_q      <= RESET_PC;
                    wrapped_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
                ST_FETCH: if (push) begin
                    pc_q <= pc_q + 1'b1;
                    if (pc_q == '1) wrapped_q <= 1'b1;
                    if (rom_data == HALT_OPCODE) begin
                        state_q <= ST_HALTED;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    state_q <= ST_STALL;
                end
                ST_STALL: if (fifo_space) state_q <= ST_FETCH;
                ST_HALTED: if (start) begin
                    state_q   <= ST_FETCH;
                    wrapped_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo2 #(.W(AW + DW)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .push_i       (push),
        .push_data_i  ({pc_q, rom_data}),
        .space_o      (fifo_space),
        .head_valid_o (instr_valid),
        .head_ready_i (instr_ready),
        .head_data_o  (head)
    );

    assign rom_addr   = pc_q;
    assign instr_pc   = head[AW+DW-1:DW];
    assign instr_data = head[DW-1:0];
    assign busy       = busy_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized ready/redirect
// run scored against an in-order {pc, rom[pc]} delivery model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  rom_addr, instr_pc;
    logic [15:0] rom_data, instr_data;
    logic        instr_valid, busy, wrapped;
    logic [15:0] rom [256];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .busy(busy), .wrapped(wrapped)
    );

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic load_rom;
        for (int a = 0; a < 256; a++) rom[a] = 16'h1000 + 16'(a);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        n_vec++; if (instr_data !== 16'h0) begin n_err++; $display("FAIL rst_data got=%0h exp=0", instr_data); end
        n_vec++; if (instr_pc !== 8'h0) begin n_err++; $display("FAIL rst_pc got=%0h exp=0", instr_pc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        n_vec++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL rst_wrapped got=%0h exp=0", wrapped); end
        n_vec++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr got=%0h exp=0", rom_addr); end
        rst_n = 1'b1;
        tick;
        tick;
        n_vec++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_fetch busy=%0h valid=%0h exp=0,0", busy, instr_valid); end
    endtask

    task automatic test_stream;
        instr_ready = 1'b1;
        pulse_start;
        n_vec++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_start busy=%0h valid=%0h exp=1,0", busy, instr_valid); end
        for (int i = 0; i < 10; i++) begin
            tick;
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr_data !== 16'h1000 + 16'(i)) begin
                n_err++; $display("FAIL stream_%0d got v=%0h pc=%0h d=%0h exp v=1 pc=%0h d=%0h", i, instr_valid, instr_pc, instr_data, i, 16'h1000 + 16'(i));
            end
        end
        halt_req = 1'b1; tick; halt_req = 1'b0;
        n_vec++; if (busy !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 8'h0A) begin
            n_err++; $display("FAIL halt_req busy=%0h valid=%0h addr=%0h exp 0,0,0a", busy, instr_valid, rom_addr);
        end
    endtask

    task automatic test_stall_random;
        logic [7:0]   exp_pc;
        logic         hold_chk, rdy, redir;
        fetch_entry_t held;
        int           delivered;
        do_reset;
        pulse_start;
        for (int i = 0; i < 5; i++) tick;
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 16'h1000 || rom_addr !== 8'h02 || busy !== 1'b1) begin
            n_err++; $display("FAIL stall_hold v=%0h pc=%0h d=%0h addr=%0h busy=%0h exp 1,00,1000,02,1", instr_valid, instr_pc, instr_data, rom_addr, busy);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k)) begin
                n_err++; $display("FAIL stall_release_%0d v=%0h pc=%0h exp 1,%0h", k, instr_valid, instr_pc, k);
            end
            tick;
        end
        exp_pc = 8'h06; hold_chk = 1'b0; held = '0; delivered = 0;
        for (int c = 0; c < 300; c++) begin
            if (hold_chk) begin
                n_vec++; if (instr_valid !== 1'b1 || instr_pc !== held.pc || instr_data !== held.code) begin
                    n_err++; $display("FAIL rand_hold c=%0d v=%0h pc=%0h d=%0h exp 1,%0h,%0h", c, instr_valid, instr_pc, instr_data, held.pc, held.code);
                end
            end
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            instr_ready = rdy; redirect_valid = redir; redirect_pc = 8'($urandom);
            if (instr_valid && rdy && !redir) begin
                n_vec++; if (instr_pc !== exp_pc || instr_data !== rom[exp_pc]) begin
                    n_err++; $display("FAIL rand_order c=%0d pc=%0h d=%0h exp %0h,%0h", c, instr_pc, instr_data, exp_pc, rom[exp_pc]);
                end
                exp_pc++; delivered++;
            end
            hold_chk = instr_valid && !rdy && !redir;
            held.pc = instr_pc; held.code = instr_data;
            if (redir) exp_pc = redirect_pc;
            tick;
        end
        redirect_valid = 1'b0;
        n_vec++; if (delivered < 80) begin n_err++; $display("FAIL rand_progress delivered=%0d exp>=80", delivered); end
    endtask

    task automatic test_redirect;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL redir_pre valid=%0h exp 1", instr_valid); end
        redirect_valid = 1'b1; redirect_pc = 8'h40; instr_ready = 1'b1;
        tick;
        redirect_valid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0 || rom_addr !== 8'h40 || busy !== 1'b1) begin
            n_err++; $display("FAIL redir_flush v=%0h addr=%0h busy=%0h exp 0,40,1", instr_valid, rom_addr, busy);
        end
        for (int k = 0; k < 2; k++) begin
            tick;
            n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40 + 8'(k) || instr_data !== 16'h1040 + 16'(k)) begin
                n_err++; $display("FAIL redir_target_%0d v=%0h pc=%0h d=%0h exp 1,%0h", k, instr_valid, instr_pc, instr_data, 8'h40 + 8'(k));
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] seq [3];
        seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        tick;
        redirect_valid = 1'b0;
        n_vec++; if (wrapped !== 1'b0 || rom_addr !== 8'hFE) begin n_err++; $display("FAIL wrap_redir wrapped=%0h addr=%0h exp 0,fe", wrapped, rom_addr); end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_vec++; if (instr_valid !== 1'b1 || instr_pc !== seq[k] || wrapped !== (k >= 1)) begin
                n_err++; $display("FAIL wrap_seq_%0d v=%0h pc=%0h wrapped=%0h exp 1,%0h,%0h", k, instr_valid, instr_pc, wrapped, seq[k], (k >= 1));
            end
        end
        halt_req = 1'b1; tick; halt_req = 1'b0;
        n_vec++; if (wrapped !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL wrap_sticky wrapped=%0h busy=%0h exp 1,0", wrapped, busy); end
        pulse_start;
        n_vec++; if (wrapped !== 1'b0 || rom_addr !== 8'h00 || busy !== 1'b1) begin
            n_err++; $display("FAIL wrap_clear wrapped=%0h addr=%0h busy=%0h exp 0,00,1", wrapped, rom_addr, busy);
        end
    endtask

    task automatic test_halt_opcode;
        do_reset;
        rom[3] = 16'hFFFF;
        instr_ready = 1'b1;
        pulse_start;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_data !== rom[k]) begin
                n_err++; $display("FAIL halt_seq_%0d v=%0h pc=%0h d=%0h exp 1,%0h,%0h", k, instr_valid, instr_pc, instr_data, k, rom[k]);
            end
        end
        n_vec++; if (busy !== 1'b0 || rom_addr !== 8'h04) begin n_err++; $display("FAIL halted busy=%0h addr=%0h exp 0,04", busy, rom_addr); end
        for (int i = 0; i < 4; i++) tick;
        n_vec++; if (instr_valid !== 1'b0 || rom_addr !== 8'h04) begin n_err++; $display("FAIL halted_idle v=%0h addr=%0h exp 0,04", instr_valid, rom_addr); end
        pulse_start;
        tick;
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || instr_data !== 16'h1004 || busy !== 1'b1) begin
            n_err++; $display("FAIL halt_resume v=%0h pc=%0h d=%0h busy=%0h exp 1,04,1004,1", instr_valid, instr_pc, instr_data, busy);
        end
        rom[3] = 16'h1003;
    endtask

    task automatic test_async_reset;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        n_vec++; if (instr_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL areset_pre v=%0h busy=%0h exp 1,1", instr_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (instr_valid !== 1'b0 || instr_data !== 16'h0 || instr_pc !== 8'h0) begin
            n_err++; $display("FAIL areset_fifo v=%0h d=%0h pc=%0h exp 0,0,0", instr_valid, instr_data, instr_pc);
        end
        n_vec++; if (busy !== 1'b0 || wrapped !== 1'b0 || rom_addr !== 8'h00) begin
            n_err++; $display("FAIL areset_ctl busy=%0h wrapped=%0h addr=%0h exp 0,0,0", busy, wrapped, rom_addr);
        end
        tick; tick;
        rst_n = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_vec++; if (instr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 8'h00) begin
                n_err++; $display("FAIL areset_nostart_%0d v=%0h busy=%0h addr=%0h exp 0,0,0", i, instr_valid, busy, rom_addr);
            end
        end
    endtask

    initial begin
        load_rom;
        test_reset;
        test_stream;
        test_stall_random;
        test_redirect;
        test_wrap;
        test_halt_opcode;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the asynchronous-read program_rom (8-bit address, 16-bit code word). It owns the program counter, drives the ROM address, and captures each fetched word with its PC into a 2-entry output FIFO. Downstream decode consumes the FIFO through a valid/ready handshake. Branch redirects and a halt opcode steer the sequence.

Parameters:
AW, 8, ROM address / PC width
DW, 16, ROM code word width
RESET_PC, 8'h00, PC value after reset and on start from IDLE
HALT_OPCODE, 16'hFFFF, code word that stops fetching after it is enqueued

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin fetching from IDLE or HALTED (single-cycle pulse)
halt_req  input  1  stop fetching; return to IDLE
redirect_valid  input  1  branch/jump: load new PC, flush FIFO
redirect_pc  input  AW  redirect target
rom_addr  output  AW  address to program_rom, equals pc register
rom_data  input  DW  program_rom code output, valid in the same cycle (combinational ROM)
instr_valid  output  1  FIFO head valid
instr_ready  input  1  consumer accepts head
instr_data  output  DW  FIFO head code word
instr_pc  output  AW  PC of FIFO head
busy  output  1  high in FETCH or STALL
wrapped  output  1  sticky; set when PC increments 0xFF->0x00, cleared by start or redirect

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, FIFO empty, instr_valid=0, instr_data=0, instr_pc=0, busy=0, wrapped=0. Deassertion is used synchronously; fetch starts only after start.
- States: IDLE, FETCH, STALL, HALTED.
- IDLE: rom_addr=pc. start -> FETCH with pc=RESET_PC, wrapped=0.
- FETCH: each cycle, if the FIFO has space (count<2, or count==2 and pop in same cycle), push {pc, rom_data} and set pc<=pc+1 (modulo 2^AW). 0xFF+1 -> 0x00 sets wrapped. If no space -> STALL; pc holds.
- STALL: no push; return to FETCH in the cycle after space exists. Fetch latency is one cycle from ROM read to instr_valid.
- Halt opcode: if the pushed word equals HALT_OPCODE, it is enqueued, pc advances, and the state becomes HALTED. HALTED: no pushes; FIFO still drains; start -> FETCH continues from the current pc.
- halt_req in FETCH/STALL: no push that cycle -> IDLE; FIFO contents are kept and drain normally.
- Redirect (any state except IDLE): FIFO flushed (count=0, instr_valid=0 next cycle), pc<=redirect_pc, wrapped=0, no push that cycle, state -> FETCH. This also exits HALTED.
- Priority (highest first): reset, redirect_valid, halt_req, start, normal fetch. A pop coincident with redirect is discarded (flush wins).
- FIFO: 2 entries; simultaneous push and pop at count==2 is legal (count stays 2). instr_data/instr_pc hold their values while instr_valid=1 and instr_ready=0. Order is strictly the fetch order.
- busy = (state==FETCH or state==STALL).

Decomposition:
- Package fetch_pkg: state enum (IDLE, FETCH, STALL, HALTED), AW/DW defaults, RESET_PC, HALT_OPCODE constants, a fetch-entry struct {pc, code}.
- Sub-module fetch_fifo2: 2-entry valid/ready FIFO with flush, parameterised on the entry width. The top module holds the PC/FSM and the ROM interface.

Test Plan:
- Reset then start, instr_ready=1, ROM loaded with 0x1000+addr -> from the cycle after start, instr_pc 0x00,0x01,... with instr_data 0x1000,0x1001,..., one entry per cycle.
- instr_ready=0 for 5 cycles after start -> two entries (pc 0x00,0x01) held, state STALL, rom_addr=0x02; release -> 0x02 is delivered next with no gaps or duplicates.
- Redirect to 0x40 while FIFO holds 2 entries -> instr_valid=0 the next cycle, then instr_pc=0x40,0x41; old entries are never delivered.
- Redirect to 0xFE, run 3 fetches -> pc sequence 0xFE,0xFF,0x00, wrapped=1 after the 0xFF fetch; a subsequent start clears it.
- ROM[0x03]=0xFFFF -> entries 0x00..0x03 delivered, then HALTED, busy=0, rom_addr=0x04; start -> resumes at 0x04.
- Assert rst_n low mid-fetch with FIFO full -> all outputs reach their reset values immediately (asynchronously); no fetch occurs until the next start.
